// File: rtl/game_timer_if.sv
// rtl/game_timer_if.sv - controller-side signal bundle for the countdown play timer
//
// Signals:
//   enable   controller -> timer  game running, counting allowed
//   reconf   controller -> timer  reload start time, clear timeout
//   tens     timer -> display     BCD tens digit of remaining time
//   ones     timer -> display     BCD ones digit of remaining time
//   timeout  timer -> controller  level, high once remaining time is 00
//   running  timer -> controller  counting active
//   warn     timer -> display     low-time warning (constant 0 unless enabled)
// Modports: master = access controller side, slave = game_timer side.

interface game_timer_if;
  logic       enable;
  logic       reconf;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       timeout;
  logic       running;
  logic       warn;

  modport master (
    output enable,
    output reconf,
    input  tens,
    input  ones,
    input  timeout,
    input  running,
    input  warn
  );

  modport slave (
    input  enable,
    input  reconf,
    output tens,
    output ones,
    output timeout,
    output running,
    output warn
  );
endinterface

// File: rtl/game_timer.sv
// rtl/game_timer.sv - two-digit BCD countdown play timer with one-second prescaler
//
// Ports:
//   CLK  system clock
//   RST  asynchronous reset, active-low
//   tif  game_timer_if.slave: enable/reconf in; tens/ones/timeout/running/warn out
// Parameters:
//   CLK_DIV     clock cycles per one-second tick (>= 2)
//   START_TENS  tens digit loaded on reset/reconf (clamped to 9)
//   START_ONES  ones digit loaded on reset/reconf (clamped to 9)
// Optional feature macro: GAME_TIMER_WARN_EN (last-ten-seconds warning);
//   when undefined, warn is tied to 0.

module game_timer #(
  parameter int         CLK_DIV    = 50000000,
  parameter logic [3:0] START_TENS = 4'd5,
  parameter logic [3:0] START_ONES = 4'd9
) (
  input  logic         CLK,
  input  logic         RST,
  game_timer_if.slave  tif
);

  localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
  localparam logic [3:0] INIT_TENS = (START_TENS > 4'd9) ? 4'd9 : START_TENS;
  localparam logic [3:0] INIT_ONES = (START_ONES > 4'd9) ? 4'd9 : START_ONES;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COUNT,
    S_EXPIRED
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    tens_q, tens_d;
  logic [3:0]    ones_q, ones_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          run_q, run_d;
  logic          timeout;

  // Timeout is simply the EXPIRED state; it needs no separate flop.
  assign timeout = (state_q == S_EXPIRED);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      tens_q  <= INIT_TENS;
      ones_q  <= INIT_ONES;
      presc_q <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      presc_q <= presc_d;
      run_q   <= run_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    presc_d = presc_q;
    // running looks at the timeout value before this edge, so it drops
    // one edge after timeout rises.
    run_d   = tif.enable & ~timeout & ~tif.reconf;

    if (tif.reconf) begin
      tens_d  = INIT_TENS;
      ones_d  = INIT_ONES;
      presc_d = '0;
      state_d = S_IDLE;
    end else if (state_q == S_EXPIRED) begin
      tens_d  = 4'd0;
      ones_d  = 4'd0;
      presc_d = '0;
    end else if (tif.enable) begin
      state_d = S_COUNT;
      if (tens_q == 4'd0 && ones_q == 4'd0) begin
        // A 00 start expires on the first enabled edge without a tick.
        state_d = S_EXPIRED;
        presc_d = '0;
      end else if (presc_q == PRESC_MAX) begin
        presc_d = '0;
        if (ones_q != 4'd0) begin
          ones_d = ones_q - 4'd1;
        end else begin
          ones_d = 4'd9;
          tens_d = tens_q - 4'd1;
        end
        // Timeout rises on the same edge the digits land on 00.
        if (tens_q == 4'd0 && ones_q == 4'd1) begin
          state_d = S_EXPIRED;
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end else begin
      // Paused: prescaler and digits hold, so a partial second survives.
      state_d = S_IDLE;
    end
  end

  assign tif.tens    = tens_q;
  assign tif.ones    = ones_q;
  assign tif.timeout = timeout;
  assign tif.running = run_q;

`ifdef GAME_TIMER_WARN_EN
  logic warn_q, warn_d;

  // Digits are always BCD, so tens==0 already implies ones<=9.
  always_comb begin
    warn_d = run_d & (state_d != S_EXPIRED) & (tens_d == 4'd0);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      warn_q <= 1'b0;
    end else begin
      warn_q <= warn_d;
    end
  end

  assign tif.warn = warn_q;
`else
  assign tif.warn = 1'b0;
`endif

endmodule

// File: tb/tb_game_timer.sv
// tb/tb_game_timer.sv - scoreboard bench for game_timer (two configurations)

module tb_game_timer;

  logic CLK;
  logic RST;

  game_timer_if ifa ();
  game_timer_if ifb ();

  game_timer #(.CLK_DIV(4), .START_TENS(4'd0), .START_ONES(4'd3)) dut_a (
    .CLK (CLK),
    .RST (RST),
    .tif (ifa)
  );

  game_timer #(.CLK_DIV(2), .START_TENS(4'd1), .START_ONES(4'd1)) dut_b (
    .CLK (CLK),
    .RST (RST),
    .tif (ifb)
  );

`ifdef GAME_TIMER_WARN_EN
  localparam bit WARN_EN = 1'b1;
`else
  localparam bit WARN_EN = 1'b0;
`endif

  typedef struct {
    int tens;
    int ones;
    int presc;
    bit tmo;
    bit run;
    bit warn;
  } mdl_t;

  mdl_t ma, mb;
  logic [10:0] qa[$];
  logic [10:0] qb[$];
  int n_checks = 0;
  int n_errors = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic mdl_t mdl_reset(input int st_t, input int st_o);
    mdl_t r;
    r.tens = st_t; r.ones = st_o; r.presc = 0;
    r.tmo = 1'b0; r.run = 1'b0; r.warn = 1'b0;
    return r;
  endfunction

  // Reference model keeps remaining time as whole seconds.
  function automatic mdl_t mdl_next(input mdl_t m, input bit en, input bit rc,
                                    input int div, input int st_t, input int st_o);
    mdl_t n;
    int secs;
    n = m;
    secs = m.tens * 10 + m.ones;
    n.run = en && !m.tmo && !rc;
    if (rc) begin
      n.tens = st_t; n.ones = st_o; n.presc = 0; n.tmo = 1'b0;
    end else if (m.tmo) begin
      n.presc = 0;
    end else if (en) begin
      if (secs == 0) begin
        n.tmo = 1'b1;
      end else if (m.presc == div - 1) begin
        n.presc = 0;
        secs = secs - 1;
        n.tens = secs / 10;
        n.ones = secs % 10;
        if (secs == 0) n.tmo = 1'b1;
      end else begin
        n.presc = m.presc + 1;
      end
    end
    n.warn = WARN_EN && n.run && !n.tmo && (n.tens == 0);
    return n;
  endfunction

  function automatic logic [10:0] pack(input mdl_t m);
    return {4'(m.tens), 4'(m.ones), m.tmo, m.run, m.warn};
  endfunction

  task automatic check(input string tag, input logic [10:0] got, input logic [10:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got tens=%h ones=%h tmo=%b run=%b warn=%b, expected tens=%h ones=%h tmo=%b run=%b warn=%b",
               tag, got[10:7], got[6:3], got[2], got[1], got[0],
               exp[10:7], exp[6:3], exp[2], exp[1], exp[0]);
    end
  endtask

  function automatic logic [10:0] obs_a();
    return {ifa.tens, ifa.ones, ifa.timeout, ifa.running, ifa.warn};
  endfunction

  function automatic logic [10:0] obs_b();
    return {ifb.tens, ifb.ones, ifb.timeout, ifb.running, ifb.warn};
  endfunction

  // Drive one cycle of stimulus, queue the expectation, compare after the edge.
  task automatic step(input string tag, input bit ea, input bit ra, input bit eb, input bit rb);
    ifa.enable = ea; ifa.reconf = ra;
    ifb.enable = eb; ifb.reconf = rb;
    if (!RST) begin
      ma = mdl_reset(0, 3);
      mb = mdl_reset(1, 1);
    end else begin
      ma = mdl_next(ma, ea, ra, 4, 0, 3);
      mb = mdl_next(mb, eb, rb, 2, 1, 1);
    end
    qa.push_back(pack(ma));
    qb.push_back(pack(mb));
    @(posedge CLK);
    #1;
    check({tag, "_a"}, obs_a(), qa.pop_front());
    check({tag, "_b"}, obs_b(), qb.pop_front());
  endtask

  initial begin
    RST = 1'b1;
    ifa.enable = 1'b0; ifa.reconf = 1'b0;
    ifb.enable = 1'b0; ifb.reconf = 1'b0;
    #1 RST = 1'b0;
    #1;
    check("rst_async_a", obs_a(), {4'd0, 4'd3, 3'b000});
    check("rst_async_b", obs_b(), {4'd1, 4'd1, 3'b000});
    ma = mdl_reset(0, 3);
    mb = mdl_reset(1, 1);
    step("rst_hold", 1'b1, 1'b0, 1'b1, 1'b0);
    RST = 1'b1;

    for (int i = 0; i < 20; i++) step("hold", 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++)  step("run2", 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step("pause", 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 30; i++) step("count", 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++)  step("exp_hold", bit'(i % 2), 1'b0, bit'((i + 1) % 2), 1'b0);
    step("reconf_en", 1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) step("recount", 1'b1, 1'b0, 1'b1, 1'b0);
    step("reconf_idle", 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++)  step("idle", 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++)  step("pre_rst", 1'b1, 1'b0, 1'b1, 1'b0);

    #2 RST = 1'b0;
    #1;
    check("rst_mid_a", obs_a(), {4'd0, 4'd3, 3'b000});
    check("rst_mid_b", obs_b(), {4'd1, 4'd1, 3'b000});
    step("rst_mid_hold", 1'b1, 1'b0, 1'b1, 1'b0);
    RST = 1'b1;
    for (int i = 0; i < 26; i++) step("post_rst", 1'b1, 1'b0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
